// File: rtl/clksrc_ctrl.sv
// rtl/clksrc_ctrl.sv - clock source selector with debounced switches and PWM hold sequencing
// Optional external-clock activity monitor is compiled in when CLKSRC_MON_EN is defined.
module clksrc_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 1024,
    parameter int MON_WINDOW      = 65536,
    parameter int MIN_EDGES       = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_ext,
    input  logic       sw_auto,
    input  logic       ext_clk_raw,
    output logic [1:0] clk_src_sel,
    output logic       pwm_hold,
    output logic       ext_present,
    output logic       fallback,
    output logic [1:0] state_dbg
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_PRE  = 2'd1,
        SWITCH    = 2'd2,
        HOLD_POST = 2'd3
    } state_t;

    // Bit 0 carries the ext switch, bit 1 the auto switch.
    logic [1:0]      sw_in;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [DB_W-1:0] db_cnt [2];

    assign sw_in = {sw_auto, sw_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef CLKSRC_MON_EN
    localparam int WIN_W  = $clog2(MON_WINDOW + 1);
    localparam int EDGE_W = $clog2(MIN_EDGES + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(MON_WINDOW - 1);
    localparam logic [EDGE_W-1:0] EDGE_MIN = EDGE_W'(MIN_EDGES);

    // ext_pipe: [0] first sync flop, [1] second sync flop, [2] previous sample
    logic [2:0]        ext_pipe;
    logic [WIN_W-1:0]  win_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              ext_rise;

    assign ext_rise = ext_pipe[1] & ~ext_pipe[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pipe    <= '0;
            win_cnt     <= '0;
            edge_cnt    <= '0;
            ext_present <= 1'b0;
            fallback    <= 1'b0;
        end else begin
            ext_pipe <= {ext_pipe[1:0], ext_clk_raw};
            fallback <= db[0] & ~ext_present;
            // An edge landing on the wrap cycle is dropped, not carried into the next window.
            if (win_cnt == WIN_LAST) begin
                win_cnt     <= '0;
                edge_cnt    <= '0;
                ext_present <= (edge_cnt >= EDGE_MIN);
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                if (ext_rise && (edge_cnt != EDGE_MIN))
                    edge_cnt <= edge_cnt + EDGE_W'(1);
            end
        end
    end
`else
    logic unused_ext_clk;

    assign unused_ext_clk = ext_clk_raw;
    assign ext_present    = 1'b1;
    assign fallback       = 1'b0;
`endif

    state_t            state;
    state_t            state_nx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nx;
    logic [1:0]        sel_nx;
    logic [1:0]        target;

    assign target = {db[1], db[0] & ext_present};

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        sel_nx      = clk_src_sel;
        case (state)
            IDLE: begin
                if (target != clk_src_sel) begin
                    state_nx    = HOLD_PRE;
                    hold_cnt_nx = '0;
                end
            end
            HOLD_PRE: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx    = SWITCH;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            SWITCH: begin
                sel_nx   = target;
                state_nx = HOLD_POST;
            end
            HOLD_POST: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nx    = IDLE;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // pwm_hold follows the next state so it is registered yet aligned with the state it reflects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            clk_src_sel <= 2'b00;
            pwm_hold    <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            clk_src_sel <= sel_nx;
            pwm_hold    <= (state_nx != IDLE);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_clksrc_ctrl.sv
// tb/tb_clksrc_ctrl.sv - self-checking bench for clksrc_ctrl
// Cycle-level reference model plus directed scenarios; monitor checks need CLKSRC_MON_EN.
module tb_clksrc_ctrl;
    localparam int D  = 4;
    localparam int H  = 8;
    localparam int MW = 64;
    localparam int ME = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_ext;
    logic       sw_auto;
    logic       ext_clk_raw = 1'b0;
    logic       ext_run = 1'b1;
    logic [1:0] clk_src_sel;
    logic       pwm_hold;
    logic       ext_present;
    logic       fallback;
    logic [1:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int sel_changes = 0;

    clksrc_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES(H),
        .MON_WINDOW(MW),
        .MIN_EDGES(ME)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_ext(sw_ext),
        .sw_auto(sw_auto),
        .ext_clk_raw(ext_clk_raw),
        .clk_src_sel(clk_src_sel),
        .pwm_hold(pwm_hold),
        .ext_present(ext_present),
        .fallback(fallback),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // External clock at clk/4: toggle every second cycle while enabled.
    always begin
        @(posedge clk);
        @(posedge clk);
        #1;
        if (ext_run) ext_clk_raw = ~ext_clk_raw;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: switch histories, run lengths and a sequence timeline position
    // (-1 idle, 0..H-1 pre-hold, H switch, H+1..2H post-hold).
    logic [1:0] m_s1, m_s2, m_db;
    int         m_run [2];
    int         m_pos;
    logic [1:0] m_sel;
    logic       m_present;
    logic       m_fb;
    logic [2:0] m_ex;
    int         m_edges;
    int         m_cycles;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic [1:0] tgt;
        logic       rise;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0;
            m_run[0] = 0; m_run[1] = 0;
            m_pos = -1; m_sel = 2'b00;
            m_ex = 0; m_edges = 0; m_cycles = 0;
`ifdef CLKSRC_MON_EN
            m_present = 1'b0;
`else
            m_present = 1'b1;
`endif
            m_fb = 1'b0;
            m_valid = 1'b1;
        end else begin
            tgt = {m_db[1], m_db[0] & m_present};
`ifdef CLKSRC_MON_EN
            rise = m_ex[1] & ~m_ex[2];
            m_fb = m_db[0] & ~m_present;
            if ((m_cycles % MW) == MW - 1) begin
                m_present = (m_edges >= ME);
                m_edges = 0;
            end else if (rise && m_edges < ME) begin
                m_edges++;
            end
            m_cycles++;
            m_ex = {m_ex[1:0], ext_clk_raw};
`else
            rise = 1'b0;
`endif
            if (m_pos < 0) begin
                if (tgt != m_sel) m_pos = 0;
            end else begin
                if (m_pos == H) m_sel = tgt;
                m_pos = (m_pos == 2 * H) ? -1 : m_pos + 1;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_db[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {sw_auto, sw_ext};
        end
    end

    logic [1:0] prev_sel = 2'b00;

    always @(negedge clk) begin
        int exp_state;
        if (m_valid) begin
            exp_state = (m_pos < 0) ? 0 : (m_pos < H) ? 1 : (m_pos == H) ? 2 : 3;
            check("model clk_src_sel", 32'(clk_src_sel), 32'(m_sel));
            check("model pwm_hold", 32'(pwm_hold), 32'(m_pos >= 0));
            check("model ext_present", 32'(ext_present), 32'(m_present));
            check("model fallback", 32'(fallback), 32'(m_fb));
            check("model state_dbg", 32'(state_dbg), 32'(exp_state));
            if (clk_src_sel !== prev_sel) sel_changes++;
            prev_sel = clk_src_sel;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input logic val, input int max, output int n);
        n = 0;
        while (pwm_hold !== val && n < max) begin step(1); n++; end
    endtask

    task automatic wait_sel(input logic [1:0] val, input int max, output int n);
        n = 0;
        while (clk_src_sel !== val && n < max) begin step(1); n++; end
    endtask

    task automatic wait_present(input logic val, input int max, output int n);
        n = 0;
        while (ext_present !== val && n < max) begin step(1); n++; end
    endtask

    task automatic wait_fb(input logic val, input int max, output int n);
        n = 0;
        while (fallback !== val && n < max) begin step(1); n++; end
    endtask

    initial begin
        int n;
        int base;
        bit hold_seen;
        rst = 1'b1; sw_ext = 1'b0; sw_auto = 1'b0;
        step(2);
        rst = 1'b0;
        check("reset sel", 32'(clk_src_sel), 32'd0);
        check("reset hold", 32'(pwm_hold), 32'd0);
        check("reset fallback", 32'(fallback), 32'd0);
`ifdef CLKSRC_MON_EN
        check("reset present", 32'(ext_present), 32'd0);
`endif
        step(20);
        check("idle sel", 32'(clk_src_sel), 32'd0);
        check("idle hold", 32'(pwm_hold), 32'd0);
        check("idle state", 32'(state_dbg), 32'd0);

        // Short glitch on sw_auto must be rejected.
        sw_auto = 1'b1; step(3); sw_auto = 1'b0;
        hold_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (pwm_hold !== 1'b0 || state_dbg !== 2'd0) hold_seen = 1'b1;
        end
        check("pulse no sequence", 32'(hold_seen), 32'd0);

        // Clean request: 2+4 cycles debounce, hold, switch, hold.
        sw_auto = 1'b1;
        wait_hold(1'b1, 30, n); check("auto hold rise latency", n, 7);
        wait_sel(2'b10, 30, n); check("auto sel latency", n, 9);
        wait_hold(1'b0, 30, n); check("auto hold fall latency", n, 8);

`ifdef CLKSRC_MON_EN
        wait_present(1'b1, 200, n); check("present before ext tests", 32'(ext_present), 32'd1);
`endif
        // Target changes during pre-hold: one switch straight to the latest target.
        base = sel_changes;
        sw_ext = 1'b1;
        wait_hold(1'b1, 30, n); check("ext hold rise latency", n, 7);
        sw_auto = 1'b0;
        wait_sel(2'b01, 30, n); check("absorbed switch latency", n, 9);
        wait_hold(1'b0, 30, n); check("absorbed hold fall", n, 8);
        step(1);
        check("single sel change", sel_changes - base, 1);

        // Target changes during post-hold: a second full sequence follows.
        sw_ext = 1'b0;
        wait_sel(2'b00, 40, n); check("ext off sel latency", n, 16);
        sw_auto = 1'b1;
        wait_hold(1'b0, 30, n); check("post hold fall", n, 8);
        wait_hold(1'b1, 30, n); check("second seq start", n, 1);
        wait_sel(2'b10, 30, n); check("second seq sel", n, 9);
        wait_hold(1'b0, 30, n); check("second seq hold fall", n, 8);

        // Reset in the middle of post-hold.
        sw_auto = 1'b0;
        wait_sel(2'b00, 40, n); check("pre-reset sel latency", n, 16);
        step(3);
        rst = 1'b1;
        step(1);
        check("mid reset sel", 32'(clk_src_sel), 32'd0);
        check("mid reset hold", 32'(pwm_hold), 32'd0);
        check("mid reset state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        hold_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (pwm_hold !== 1'b0 || state_dbg !== 2'd0) hold_seen = 1'b1;
        end
        check("no residual sequence", 32'(hold_seen), 32'd0);

`ifdef CLKSRC_MON_EN
        // Ext selection gated by detected activity, then loss of the clock.
        sw_ext = 1'b1;
        wait_present(1'b1, 200, n); check("ext detected", 32'(ext_present), 32'd1);
        wait_sel(2'b01, 60, n); check("ext selected", 32'(clk_src_sel), 32'd1);
        ext_run = 1'b0;
        wait_present(1'b0, 200, n); check("ext lost", 32'(ext_present), 32'd0);
        wait_fb(1'b1, 5, n); check("fallback latency", n, 1);
        wait_sel(2'b00, 30, n); check("fallback sel latency", n, 9);
        check("fallback held", 32'(fallback), 32'd1);
        step(10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clksrc_ctrl.md
CLKSRC_CTRL -- requirements
Module: clksrc_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles before a switch input is accepted (10 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 1024: length of each pre-switch and post-switch PWM hold window.
REQ-003 Parameter MON_WINDOW, default 65536: external-clock activity measurement window, in clk cycles.
REQ-004 Parameter MIN_EDGES, default 4096: minimum rising edges per window for the external clock to count as present.
REQ-005 clk  input  1  50 MHz board master clock; the block's only clock.
REQ-006 rst  input  1  reset; synchronous to clk, active-high.
REQ-007 sw_ext  input  1  asynchronous switch; 1 requests the external source.
REQ-008 sw_auto  input  1  asynchronous switch; 1 requests the automatic slow clock, 0 requests the button clock.
REQ-009 ext_clk_raw  input  1  external 6.5536 MHz pin, sampled asynchronously.
REQ-010 clk_src_sel  output  2  bit0 = ext(1)/int(0); bit1 = auto(1)/manual(0); drives the clock unit's source select.
REQ-011 pwm_hold  output  1  1 tells downstream PWM logic to freeze outputs while the source changes.
REQ-012 ext_present  output  1  external clock is currently detected.
REQ-013 fallback  output  1  external source is requested (debounced) but not present, so the internal source is in use.
REQ-014 state_dbg  output  2  encoded FSM state: IDLE=0, HOLD_PRE=1, SWITCH=2, HOLD_POST=3.

Function
REQ-015 Each switch input SHALL pass through a 2-flop synchroniser and then a debouncer.
REQ-016 Debounce rule: the debounced value updates only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement clears the counter.
REQ-017 ext_clk_raw SHALL be synchronised by 2 flops; a rising edge is detected as sync2 = 1 with the previous sample = 0.
REQ-018 Edge counter: saturates at MIN_EDGES; a window counter counts 0..MON_WINDOW-1 and wraps.
REQ-019 On the window-wrap cycle, ext_present SHALL load (edge count >= MIN_EDGES), and the edge counter SHALL clear, ignoring any edge detected in that same cycle.
REQ-020 Target source: target = {auto_db, ext_db & ext_present}.
REQ-021 fallback SHALL be registered as ext_db & ~ext_present.
REQ-022 IDLE: pwm_hold = 0; when target != clk_src_sel, go to HOLD_PRE next cycle.
REQ-023 HOLD_PRE: pwm_hold = 1 for HOLD_CYCLES cycles, then go to SWITCH.
REQ-024 SWITCH (1 cycle): pwm_hold = 1; clk_src_sel loads the target sampled in this cycle; then go to HOLD_POST.
REQ-025 HOLD_POST: pwm_hold = 1 for HOLD_CYCLES cycles, then go to IDLE.
REQ-026 A target change during HOLD_PRE SHALL be absorbed: the SWITCH cycle uses the latest target.
REQ-027 A change during HOLD_POST SHALL start a new sequence from IDLE after HOLD_POST completes; no state is skipped.
REQ-028 If the target at SWITCH equals clk_src_sel, the sequence SHALL still complete (no-op switch with full hold).
REQ-029 clk_src_sel SHALL change only in the SWITCH state.
REQ-030 pwm_hold SHALL be 1 from the cycle before any clk_src_sel change until HOLD_CYCLES cycles after it.
REQ-031 Loss of the external clock (ext_present falling) while ext is selected SHALL trigger a normal sequence to internal; the switch takes effect no sooner than the HOLD_CYCLES hold.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 When rst = 1 at a clk edge, all of the following SHALL take effect on the next edge, regardless of current state (mid-sequence included):
- state = IDLE;
- clk_src_sel = 2'b00, pwm_hold = 0, ext_present = 0, fallback = 0;
- debounced values = 0;
- all counters and synchroniser flops = 0.

Configuration
REQ-034 Macro CLKSRC_MON_EN, when defined: the activity monitor (REQ-017 to REQ-019) is compiled in.
REQ-035 When CLKSRC_MON_EN is undefined: the monitor logic is absent, ext_present is tied to 1, fallback is tied to 0, and ext_clk_raw is unused.

Verification
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, MON_WINDOW=64, MIN_EDGES=4.
REQ-036 Reset with both switches 0 -> clk_src_sel=00, pwm_hold=0, state_dbg=0 indefinitely.
REQ-037 sw_auto 0->1 and held -> debounced after 2+4 cycles; pwm_hold=1 next cycle; clk_src_sel=10 exactly 9 cycles after pwm_hold rises; pwm_hold=0 8 cycles later.
REQ-038 sw_auto pulsed high for 3 cycles -> no state change; pwm_hold stays 0.
REQ-039 With CLKSRC_MON_EN: ext_clk_raw toggling at clk/4, sw_ext=1 -> ext_present=1 at first window wrap; then clk_src_sel bit0=1 after the hold sequence. Stop ext_clk_raw -> ext_present=0 at the next wrap; fallback=1; bit0 returns to 0 after the hold sequence.
REQ-040 sw_ext toggled during HOLD_PRE -> single SWITCH using the latest target. Toggled during HOLD_POST -> a second full sequence follows.
REQ-041 rst asserted in HOLD_POST -> outputs at reset values the next cycle; no residual sequence after release with switches at 0.
